// File: rtl/batchnorm_channel_pipe.sv
`default_nettype none
// ============================================================================
// Module  : batchnorm_channel_pipe
// Brief   : Two-stage per-channel affine (gamma*x + beta) with clip and ReLU.
// Revision: 1.0 - initial release
// ============================================================================
module batchnorm_channel_pipe #(
    parameter  int DATA_W = 8,
    parameter  int FRAC   = 4,
    parameter  int CH     = 4,
    localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    output logic signed [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     relu_en,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic signed [DATA_W-1:0] cfg_gamma,
    input  logic signed [DATA_W-1:0] cfg_beta,
    output logic [15:0]              sat_count
);

    localparam int c_prod_w = 2 * DATA_W;
    localparam int c_sum_w  = 2 * DATA_W + 1;
    localparam logic signed [c_sum_w-1:0] c_max = c_sum_w'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [c_sum_w-1:0] c_min = c_sum_w'(-(2 ** (DATA_W - 1)));
    localparam logic signed [DATA_W-1:0]  c_one = DATA_W'(2 ** FRAC);

    logic signed [DATA_W-1:0]   r_gamma [CH];
    logic signed [DATA_W-1:0]   r_beta  [CH];
    logic [CH_W-1:0]            r_ch_cnt;
    logic                       r_s1_valid;
    logic signed [c_prod_w-1:0] r_s1_prod;
    logic signed [DATA_W-1:0]   r_s1_beta;
    logic [CH_W-1:0]            r_s1_ch;
    logic                       r_out_valid;
    logic signed [DATA_W-1:0]   r_out_data;
    logic [CH_W-1:0]            r_out_ch;
    logic                       r_out_sat;
    logic [15:0]                r_sat_count;

    logic                       w_en;
    logic                       w_acc;
    logic signed [c_prod_w-1:0] w_shift;
    logic signed [c_sum_w-1:0]  w_sum;
    logic                       w_over;
    logic                       w_under;
    logic signed [DATA_W-1:0]   w_clip;
    logic signed [DATA_W-1:0]   w_res;

    // One enable moves the whole pipeline, so a stalled output freezes every stage.
    assign w_en      = !r_out_valid || out_ready;
    assign w_acc     = in_valid && w_en;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign sat_count = r_sat_count;

    // Out-of-range cfg_ch matches no entry and is dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (!rst_n) begin
                r_gamma[i] <= c_one;
                r_beta[i]  <= '0;
            end else if (cfg_we && (cfg_ch == CH_W'(i))) begin
                r_gamma[i] <= cfg_gamma;
                r_beta[i]  <= cfg_beta;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ch_cnt <= '0;
        end else if (w_acc) begin
            if (in_last || (r_ch_cnt == CH_W'(CH - 1))) begin
                r_ch_cnt <= '0;
            end else begin
                r_ch_cnt <= r_ch_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_beta  <= '0;
            r_s1_ch    <= '0;
        end else if (w_en) begin
            r_s1_valid <= w_acc;
            if (w_acc) begin
                r_s1_prod <= in_data * r_gamma[r_ch_cnt];
                r_s1_beta <= r_beta[r_ch_cnt];
                r_s1_ch   <= r_ch_cnt;
            end
        end
    end

    assign w_shift = r_s1_prod >>> FRAC;
    assign w_sum   = {w_shift[c_prod_w-1], w_shift}
                   + {{(c_sum_w - DATA_W){r_s1_beta[DATA_W-1]}}, r_s1_beta};
    assign w_over  = w_sum > c_max;
    assign w_under = w_sum < c_min;

    always_comb begin
        w_clip = w_sum[DATA_W-1:0];
        if (w_over) begin
            w_clip = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (w_under) begin
            w_clip = {1'b1, {(DATA_W - 1){1'b0}}};
        end
        w_res = (relu_en && w_clip[DATA_W-1]) ? '0 : w_clip;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_res;
                r_out_ch   <= r_s1_ch;
                r_out_sat  <= w_over || w_under;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sat_count <= '0;
        end else if (r_out_valid && out_ready && r_out_sat && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_batchnorm_channel_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_batchnorm_channel_pipe
// Brief   : Scoreboard bench with a behavioural batchnorm reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_batchnorm_channel_pipe;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [7:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic signed [7:0] out_data;
    logic [1:0]        out_ch;
    logic              out_valid;
    logic              out_ready;
    logic              relu_en;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic signed [7:0] cfg_gamma;
    logic signed [7:0] cfg_beta;
    logic [15:0]       sat_count;

    batchnorm_channel_pipe #(.DATA_W(8), .FRAC(4), .CH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready), .relu_en(relu_en),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_gamma(cfg_gamma), .cfg_beta(cfg_beta),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int data;
        int ch;
        bit sat;
        int acc;
        bit lat;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_gamma[4];
    int   m_beta[4];
    int   m_ch;
    int   exp_sat;
    bit   lat_mode;
    bit   relu_mode;

    function automatic void check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: real-valued gamma*x scaled by 2^-4, floored, plus beta, then clip and ReLU.
    function automatic void ref_model(int x, int g, int b, bit relu, output int y, output bit s);
        int p, fl, sum;
        p   = x * g;
        fl  = (p >= 0) ? (p / 16) : -((-p + 15) / 16);
        sum = fl + b;
        s   = (sum > 127) || (sum < -128);
        y   = (sum > 127) ? 127 : (sum < -128) ? -128 : sum;
        if (relu && y < 0) y = 0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_gamma[i] = 16;
            m_beta[i]  = 0;
        end
        m_ch    = 0;
        exp_sat = 0;
        q.delete();
    endfunction

    task automatic drive_cycle(input bit v, input int d, input bit last, input bit orr,
                               input bit we, input int wch, input int wg, input int wb,
                               output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_data   = 8'(d);
        in_last   = last;
        out_ready = orr;
        relu_en   = relu_mode;
        cfg_we    = we;
        cfg_ch    = 2'(wch);
        cfg_gamma = 8'(wg);
        cfg_beta  = 8'(wb);
        #1;
        acc = 1'b0;
        if (v && in_ready) begin
            ref_model(int'(in_data), m_gamma[m_ch], m_beta[m_ch], relu_mode, e.data, e.sat);
            e.ch  = m_ch;
            e.acc = cyc;
            e.lat = lat_mode;
            q.push_back(e);
            m_ch = last ? 0 : (m_ch + 1) % 4;
            acc  = 1'b1;
        end
        if (we) begin
            m_gamma[wch] = int'(cfg_gamma);
            m_beta[wch]  = int'(cfg_beta);
        end
    endtask

    task automatic send(input int d, input bit last);
        bit acc;
        int tries = 0;
        do begin
            drive_cycle(1'b1, d, last, 1'b1, 1'b0, 0, 0, 0, acc);
            tries++;
        end while (!acc && tries < 20);
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic cfg(input int ch, input int g, input int b);
        bit acc;
        drive_cycle(1'b0, 0, 1'b0, 1'b1, 1'b1, ch, g, b, acc);
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            drive_cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0, 0, acc);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
        drive_cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0, 0, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_ch", int'(out_ch), 0);
        check("rst_sat_count", int'(sat_count), 0);
        rst_n = 1'b1;
        #0.5;
        check("rst_in_ready", int'(in_ready), 1);
    endtask

    // Monitor: pops one expectation per transfer; also polices stall behaviour.
    initial begin
        bit   stalled = 1'b0;
        int   pd = 0, pc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n !== 1'b1) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'(out_data), pd);
                check("hold_ch", int'(out_ch), pc);
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", int'(in_ready), 0);
                stalled = 1'b1;
                pd = int'(out_data);
                pc = int'(out_ch);
            end else begin
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("out_data", int'(out_data), e.data);
                    check("out_ch", int'(out_ch), e.ch);
                    if (e.lat) check("latency", cyc - e.acc, 2);
                    check("sat_count", int'(sat_count), exp_sat);
                    if (e.sat && exp_sat < 65535) exp_sat++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        relu_en   = 1'b0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_gamma = '0;
        cfg_beta  = '0;
        relu_mode = 1'b0;
        lat_mode  = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Identity coefficients after reset
        send(16, 0); send(-16, 0); send(5, 0); send(0, 0);
        drain();

        // Custom gamma/beta, then same beats with ReLU
        cfg(0, 24, 4);
        send(16, 1); send(-16, 1);
        drain();
        relu_mode = 1'b1;
        send(16, 1); send(-16, 1);
        drain();
        relu_mode = 1'b0;

        // Floor rounding and saturation
        cfg(0, 24, 0);
        send(1, 1); send(-1, 1);
        cfg(0, 32, 0);
        send(127, 1); send(-128, 1);
        drain();
        check("sat_count_total", int'(sat_count), 2);

        // Channel wrap and in_last
        for (int i = 0; i < 6; i++) send(i + 1, 0);
        send(7, 0); send(8, 1); send(9, 0);
        drain();

        // Backpressure window with a continuous input stream
        lat_mode = 1'b0;
        cfg(1, -40, 7);
        for (int i = 0; i < 12; i++)
            drive_cycle(1'b1, i * 11 - 60, 1'b0, !(i >= 3 && i < 6), 1'b0, 0, 0, 0, acc);
        drain();

        // Reset with beats in flight; coefficients must return to identity
        cfg(0, 24, 4);
        send(20, 0); send(30, 0);
        do_reset();
        lat_mode = 1'b1;
        send(16, 1); send(-100, 1);
        drain();
        lat_mode = 1'b0;

        // Randomised traffic with occasional reconfiguration
        for (int ph = 0; ph < 2; ph++) begin
            relu_mode = ph[0];
            for (int i = 0; i < 300; i++) begin
                drive_cycle(($urandom % 4) != 0, int'($urandom % 256) - 128,
                            ($urandom % 8) == 0, ($urandom % 4) != 0,
                            ($urandom % 16) == 0, int'($urandom % 4),
                            int'($urandom % 256) - 128, int'($urandom % 256) - 128, acc);
            end
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/batchnorm_channel_pipe.md
BATCHNORM_CHANNEL_PIPE -- requirements
Module: batchnorm_channel_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed Q-format sample/coefficient width.
REQ-002 SHALL have parameter FRAC, default 4, fractional bits of data, gamma and beta.
REQ-003 SHALL have parameter CH, default 4, channel count (>=2); CH_W = clog2(CH), derived localparam.
REQ-004 SHALL have ports:
  - clk  in  1  rising-edge clock, single clock domain.
  - rst_n  in  1  synchronous, active-low reset.
  - in_data  in  DATA_W  signed input sample.
  - in_valid  in  1  input beat valid.
  - in_ready  out  1  block accepts beat.
  - in_last  in  1  last beat of a pixel; forces channel counter to 0 after acceptance.
  - out_data  out  DATA_W  signed normalised result.
  - out_ch  out  CH_W  channel index of out_data.
  - out_valid  out  1  result valid.
  - out_ready  in  1  downstream accepts result.
  - relu_en  in  1  1 = clamp negative results to 0.
  - cfg_we  in  1  coefficient write strobe.
  - cfg_ch  in  CH_W  channel written.
  - cfg_gamma  in  DATA_W  signed gamma.
  - cfg_beta  in  DATA_W  signed beta.
  - sat_count  out  16  count of saturated outputs.

Function
REQ-005 SHALL store per-channel gamma and beta in registers; cfg_we writes both for cfg_ch on the clock edge; cfg_ch >= CH ignored.
REQ-006 SHALL accept a beat when in_valid && in_ready; in_ready = !out_valid || out_ready (global pipeline enable).
REQ-007 SHALL keep channel counter ch_cnt: +1 per accepted beat, wraps CH-1 -> 0; accepted beat with in_last=1 sets ch_cnt to 0.
REQ-008 Stage 1 SHALL register product in_data*gamma[ch_cnt] (2*DATA_W signed), beta[ch_cnt], ch_cnt and valid.
REQ-009 Stage 2 SHALL compute (product >>> FRAC) + sign-extended beta at 2*DATA_W+1 bits; arithmetic shift, floor rounding.
REQ-010 SHALL saturate the sum to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; then, if relu_en, negative values become 0.
REQ-011 relu_en SHALL be sampled in stage 2.
REQ-012 Latency SHALL be 2 cycles from acceptance to out_valid with no stall; throughput 1 beat/cycle.
REQ-013 When out_valid && !out_ready, out_data/out_ch/out_valid and all stage registers SHALL hold; no beat lost or duplicated.
REQ-014 Coefficients SHALL be read at acceptance; a cfg write in the same cycle as acceptance of that channel uses the old value; the new value applies from the next cycle.
REQ-015 sat_count SHALL increment by 1 per output transferred (out_valid && out_ready) whose pre-clip sum was out of range, and saturate at 16'hFFFF.
REQ-016 Mid-stream relu_en changes SHALL affect only results not yet transferred.

Reset
REQ-017 On rst_n=0 at a clock edge: out_valid=0, out_data=0, out_ch=0, stage-1 valid=0, ch_cnt=0, sat_count=0.
REQ-018 Reset SHALL set every gamma to 2^FRAC (1.0) and every beta to 0.
REQ-019 Reset mid-operation SHALL discard in-flight beats; in_ready=1 in the first cycle after reset release.

Verification (DATA_W=8, FRAC=4, CH=4)
REQ-020 After reset, no cfg writes, stream 16,-16,5,0 on ch0..3 -> outputs 16,-16,5,0 with out_ch 0..3, 2 cycles after each acceptance.
REQ-021 cfg ch0 gamma=24, beta=4; inputs 16, -16 on ch0 (in_last=1 each) -> 28, then -20; with relu_en=1 -> 28, then 0.
REQ-022 Floor and saturation: gamma=24, beta=0, inputs 1 and -1 -> 1, -2; gamma=32, beta=0, inputs 127 and -128 -> 127, -128; sat_count=2.
REQ-023 Backpressure: continuous input, out_ready low 3 cycles -> in_ready low while out_valid held; all beats emerge in order, none lost or duplicated.
REQ-024 Wrap and in_last: 6 beats without in_last -> out_ch 0,1,2,3,0,1; in_last on beat 2 -> next beat ch0.
REQ-025 Reset asserted with 2 beats in flight -> out_valid=0 next cycle, coefficients back to gamma=16, beta=0, sat_count=0.
